pwm_duty_ctrl: RTL and testbench

- Consumes the single-cycle pushbutton pulses produced by the debounce stage: one "increase" pulse and one "decrease" pulse.
- Steps a requested duty cycle in percent and generates a glitch-free PWM output.
- A new duty value takes effect only at a PWM period boundary.
- Sits between the button debouncers and the output pin or LED driver.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_tick_gen.sv | 41 ++++
 rtl/pwm_duty_ctrl.sv | 82 ++++++++
 tb/tb_pwm_duty_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM duty controller slice.
package pwm_pkg;

  localparam int PCT_MAX = 100;
  localparam int DUTY_W  = 7;

  // Clock divider that maps one PWM period onto 100 duty steps; never below 1.
  function automatic int calc_div(input int clk_freq, input int pwm_freq);
    int div;
    div = clk_freq / (pwm_freq * PCT_MAX);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler plus 0..99 step counter; wrap marks the last step of a PWM period.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              tick,
  output logic [DUTY_W-1:0] step_cnt,
  output logic              wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0] step_q, step_d;

  always_comb begin
    tick    = (presc_q == PW'(DIV - 1));
    wrap    = tick && (step_q == DUTY_W'(PCT_MAX - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    step_d  = step_q;
    if (tick) begin
      step_d = wrap ? '0 : step_q + DUTY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  assign step_cnt = step_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Button-stepped duty request, period-boundary shadow load and registered PWM output.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int PWM_FREQ  = 1_000,
  parameter int STEP      = 10,
  parameter int DUTY_INIT = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_req,
  output logic [DUTY_W-1:0] duty_active,
  output logic              period_start
);

  localparam int DIV = calc_div(CLK_FREQ, PWM_FREQ);

  logic              tick, wrap;
  logic [DUTY_W-1:0] step_cnt;

  logic [DUTY_W-1:0] duty_req_q, duty_req_d;
  logic [DUTY_W-1:0] duty_active_q, duty_active_d;
  logic              pwm_q, pwm_d;
  logic              wrap_dly_q, wrap_dly_d;
  logic              period_start_q, period_start_d;
  logic [7:0]        sum;

  pwm_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .step_cnt (step_cnt),
    .wrap     (wrap)
  );

  // Saturating request update; the shadow copies the pre-update request at the boundary.
  always_comb begin
    sum        = {1'b0, duty_req_q} + 8'(STEP);
    duty_req_d = duty_req_q;
    if (inc_pulse && !dec_pulse) begin
      duty_req_d = (sum > 8'(PCT_MAX)) ? DUTY_W'(PCT_MAX) : sum[DUTY_W-1:0];
    end else if (dec_pulse && !inc_pulse) begin
      duty_req_d = (duty_req_q < DUTY_W'(STEP)) ? '0 : duty_req_q - DUTY_W'(STEP);
    end

    duty_active_d = duty_active_q;
    if (tick && (step_cnt == DUTY_W'(PCT_MAX - 1))) begin
      duty_active_d = duty_req_q;
    end

    pwm_d          = (step_cnt < duty_active_q);
    wrap_dly_d     = wrap;
    // Delayed twice so the pulse lines up with the first pwm_out cycle of the period.
    period_start_d = wrap_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_req_q     <= DUTY_W'(DUTY_INIT);
      duty_active_q  <= DUTY_W'(DUTY_INIT);
      pwm_q          <= 1'b0;
      wrap_dly_q     <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      duty_req_q     <= duty_req_d;
      duty_active_q  <= duty_active_d;
      pwm_q          <= pwm_d;
      wrap_dly_q     <= wrap_dly_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign duty_req     = duty_req_q;
  assign duty_active  = duty_active_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with DIV=1 (100-clock periods), STEP=10.
module tb_pwm_duty_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_pulse = 1'b0, dec_pulse = 1'b0;
  logic       inc95 = 1'b0;
  logic       pwm_out, period_start;
  logic [6:0] duty_req, duty_active;
  logic       pwm95, start95;
  logic [6:0] req95, active95;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int highs = 0;
  int starts = 0;

  always #5 clk = ~clk;

  pwm_duty_ctrl #(.CLK_FREQ(1000), .PWM_FREQ(10), .STEP(10), .DUTY_INIT(50)) dut (
    .clk          (clk),
    .rst          (rst),
    .inc_pulse    (inc_pulse),
    .dec_pulse    (dec_pulse),
    .pwm_out      (pwm_out),
    .duty_req     (duty_req),
    .duty_active  (duty_active),
    .period_start (period_start)
  );

  pwm_duty_ctrl #(.CLK_FREQ(1000), .PWM_FREQ(10), .STEP(10), .DUTY_INIT(95)) dut95 (
    .clk          (clk),
    .rst          (rst),
    .inc_pulse    (inc95),
    .dec_pulse    (1'b0),
    .pwm_out      (pwm95),
    .duty_req     (req95),
    .duty_active  (active95),
    .period_start (start95)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One clock: sample outputs at the falling edge and accumulate window statistics.
  task automatic advance();
    @(negedge clk);
    cyc++;
    if (pwm_out === 1'b1) highs++;
    if (period_start === 1'b1) starts++;
  endtask

  task automatic runCycles(input int n);
    repeat (n) advance();
  endtask

  task automatic measure(input int n);
    highs  = 0;
    starts = 0;
    runCycles(n);
  endtask

  task automatic applyStimulus(input logic inc, input logic dec, input logic i95, input int n);
    inc_pulse = inc;
    dec_pulse = dec;
    inc95     = i95;
    runCycles(n);
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    inc95     = 1'b0;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_rst_pwm"}, int'(pwm_out), 0);
    checkOutput({tag, "_rst_req"}, int'(duty_req), 50);
    checkOutput({tag, "_rst_active"}, int'(duty_active), 50);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("init_pwm", int'(pwm_out), 0);
    checkOutput("init_start", int'(period_start), 0);
    checkOutput("init_req", int'(duty_req), 50);
    checkOutput("init_active", int'(duty_active), 50);
    checkOutput("init95_active", int'(active95), 95);
    rst = 1'b0;
    cyc = 0;

    // 1: three free-running periods at 50 %
    measure(300);
    checkOutput("t1_highs", highs, 150);
    checkOutput("t1_starts", starts, 2);
    checkOutput("t1_req", int'(duty_req), 50);
    checkOutput("t1_active", int'(duty_active), 50);

    // 2: three increments mid-period, applied at next boundary
    runCycles(30);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("t2_req", int'(duty_req), 80);
    checkOutput("t2_active_hold", int'(duty_active), 50);
    runCycles(66);
    checkOutput("t2_active_pre_wrap", int'(duty_active), 50);
    advance();
    checkOutput("t2_active_post_wrap", int'(duty_active), 80);
    measure(100);
    checkOutput("t2_highs", highs, 80);
    checkOutput("t2_starts", starts, 1);

    // 3: saturate at 100, no low glitch across wraps
    doReset("t3");
    runCycles(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 6);
    checkOutput("t3_req", int'(duty_req), 100);
    runCycles(84);
    measure(200);
    checkOutput("t3_highs", highs, 200);
    checkOutput("t3_starts", starts, 2);

    // 4: floor at 0
    doReset("t4");
    runCycles(10);
    applyStimulus(1'b0, 1'b1, 1'b0, 6);
    checkOutput("t4_req", int'(duty_req), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("t4_req_extra", int'(duty_req), 0);
    runCycles(83);
    measure(100);
    checkOutput("t4_highs", highs, 0);
    checkOutput("t4_active", int'(duty_active), 0);

    // 5: simultaneous pulses, 95+10 clamp, request landing on the wrap clock
    doReset("t5");
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("t5_both_req", int'(duty_req), 50);
    checkOutput("t5_95_req", int'(req95), 100);
    runCycles(98);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("t5_race_req", int'(duty_req), 60);
    checkOutput("t5_race_active", int'(duty_active), 50);
    checkOutput("t5_95_active", int'(active95), 100);
    runCycles(100);
    checkOutput("t5_late_active", int'(duty_active), 60);

    // 6: reset in the middle of an 80 % period
    doReset("t6");
    runCycles(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    runCycles(87);
    checkOutput("t6_active80", int'(duty_active), 80);
    runCycles(30);
    checkOutput("t6_pwm_before", int'(pwm_out), 1);
    rst = 1'b1;
    inc_pulse = 1'b1;
    #1;
    checkOutput("t6_pwm_async", int'(pwm_out), 0);
    checkOutput("t6_active_async", int'(duty_active), 50);
    checkOutput("t6_req_async", int'(duty_req), 50);
    @(negedge clk);
    rst = 1'b0;
    inc_pulse = 1'b0;
    cyc = 0;
    measure(100);
    checkOutput("t6_highs", highs, 50);
    checkOutput("t6_starts", starts, 0);
    advance();
    checkOutput("t6_first_start", int'(period_start), 1);
    checkOutput("t6_first_pwm", int'(pwm_out), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
